jtag_host_driver: RTL and testbench

//  Bit-banged JTAG initiator: drives TCK/TMS/TDI and samples TDO to run complete IR+DR scans against a TAP.

---
 rtl/jtag_host_pkg.sv | 32 +++
 rtl/jtag_tck_gen.sv | 54 +++++
 rtl/jtag_host_driver.sv | 182 ++++++++++++++++++
 tb/tb_jtag_host_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_host_pkg.sv
// Shared definitions for the JTAG host driver.
//   state_e      : driver FSM states
//   *_TMS        : fixed TMS patterns for header/tail segments, bit 0 driven first
//   RESET_TCK    : TCK count of the TMS reset sequence (5 x TMS=1, 1 x TMS=0)
package jtag_host_pkg;

    typedef enum logic [3:0] {
        RESET_SEQ,
        IDLE,
        IR_HDR,
        IR_SHIFT,
        IR_TAIL,
        DR_HDR,
        DR_SHIFT,
        DR_TAIL,
        DONE
    } state_e;

    // Run-Test/Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam logic [3:0] IR_HDR_TMS  = 4'b0011;
    // Exit1-IR -> Update-IR -> Select-DR
    localparam logic [1:0] IR_TAIL_TMS = 2'b11;
    // Select-DR -> Capture-DR -> Shift-DR
    localparam logic [1:0] DR_HDR_TMS  = 2'b00;
    // Exit1-DR -> Update-DR -> Run-Test/Idle
    localparam logic [1:0] DR_TAIL_TMS = 2'b01;

    localparam logic [6:0] RESET_TCK   = 7'd6;
    localparam logic [6:0] IR_HDR_LEN  = 7'd4;
    localparam logic [6:0] SEG2_LEN    = 7'd2;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider. While en_i is high, TCK toggles every CLK_DIV clks. The cycle
// TCK goes low (and the very first enabled cycle) carries fall_stb_o; the cycle
// TCK goes high carries rise_stb_o. When disabled TCK is held low and the
// divider restarts, so the first strobe after enable is always a fall strobe.
//   clk, rst_n   : system clock, async active-low reset
//   en_i         : run the divider
//   tck_o        : TCK
//   rise_stb_o   : 1-clk strobe, first clk of TCK high
//   fall_stb_o   : 1-clk strobe, first clk of TCK low
module jtag_tck_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tck_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_q, tck_d;

    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!en_i) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (cnt_q == CW'(CLK_DIV - 1)) begin
            cnt_d = '0;
            tck_d = !tck_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign tck_o      = tck_q;
    assign rise_stb_o = en_i && tck_q && (cnt_q == '0);
    assign fall_stb_o = en_i && !tck_q && (cnt_q == '0);

endmodule

// File: rtl/jtag_host_driver.sv
// Bit-banged JTAG initiator. One command walks the TAP from Run-Test/Idle
// through an IR scan and a DR scan and back, returning the TDO bits captured
// in each shift. A TMS reset sequence runs automatically after rst_n release
// and on tap_reset_i.
//   start_i / tap_reset_i : command strobes, accepted only when idle
//   ir_i, dr_len_i, dr_i  : scan operands, latched on an accepted start_i
//   busy_o, done_o, err_o : status; err_o marks a rejected dr_len_i
//   ir_o, dr_o            : captured TDO bits, updated with done_o
//   jtag_*                : TAP pins
module jtag_host_driver
    import jtag_host_pkg::*;
#(
    parameter int CLK_DIV  = 16,
    parameter int IR_WIDTH = 5,
    parameter int DR_MAX   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                tap_reset_i,
    input  logic [IR_WIDTH-1:0] ir_i,
    input  logic [6:0]          dr_len_i,
    input  logic [DR_MAX-1:0]   dr_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [IR_WIDTH-1:0] ir_o,
    output logic [DR_MAX-1:0]   dr_o,
    output logic                jtag_tck_o,
    output logic                jtag_tms_o,
    output logic                jtag_tdi_o,
    input  logic                jtag_tdo_i
);

    localparam int DRW = $clog2(DR_MAX);

    state_e              state_q, state_d;
    logic [6:0]          bit_q, len_q, seg_len;
    logic [IR_WIDTH-1:0] ir_sh_q, ir_ins, ir_o_q;
    logic [DR_MAX-1:0]   dr_sh_q, dr_ins, dr_o_q;
    logic [DRW-1:0]      dr_top;
    logic                err_q, tms_q, tms_d, tdi_q, tdi_d;
    logic                tck_en, rise_stb, fall_stb;
    logic                terminal, seg_last, end_fall, len_ok, accept;

    function automatic logic [DR_MAX-1:0] len_mask(input logic [6:0] n);
        logic [DR_MAX-1:0] m;
        for (int i = 0; i < DR_MAX; i++) m[i] = (i < int'(n));
        return m;
    endfunction

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (tck_en),
        .tck_o      (jtag_tck_o),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    assign len_ok = (dr_len_i != 7'd0) && (dr_len_i <= 7'(DR_MAX));
    assign accept = (state_q == IDLE) && start_i && !tap_reset_i;

    // Segment length in TCKs for the current state. Terminal segments leave
    // the state on the fall strobe after their last rise, so TCK is back low
    // before the FSM reports completion.
    always_comb begin
        seg_len  = 7'd1;
        terminal = 1'b0;
        case (state_q)
            RESET_SEQ: begin seg_len = RESET_TCK; terminal = 1'b1; end
            IR_HDR:    seg_len = IR_HDR_LEN;
            IR_SHIFT:  seg_len = 7'(IR_WIDTH);
            IR_TAIL:   seg_len = SEG2_LEN;
            DR_HDR:    seg_len = SEG2_LEN;
            DR_SHIFT:  seg_len = len_q;
            DR_TAIL:   begin seg_len = SEG2_LEN; terminal = 1'b1; end
            default:   ;
        endcase
    end

    assign seg_last = rise_stb && !terminal && (bit_q == seg_len - 7'd1);
    assign end_fall = fall_stb && terminal && (bit_q == seg_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RESET_SEQ;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET_SEQ: if (end_fall) state_d = IDLE;
            IDLE: begin
                if (tap_reset_i)  state_d = RESET_SEQ;
                else if (start_i) state_d = len_ok ? IR_HDR : DONE;
            end
            IR_HDR:   if (seg_last) state_d = IR_SHIFT;
            IR_SHIFT: if (seg_last) state_d = IR_TAIL;
            IR_TAIL:  if (seg_last) state_d = DR_HDR;
            DR_HDR:   if (seg_last) state_d = DR_SHIFT;
            DR_SHIFT: if (seg_last) state_d = DR_TAIL;
            DR_TAIL:  if (end_fall) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = RESET_SEQ;
        endcase
    end

    // Outputs and the TMS/TDI value for the next TCK, loaded on fall strobes.
    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == DONE);
        err_o  = (state_q == DONE) && err_q;
        tck_en = (state_q != IDLE) && (state_q != DONE);
        tms_d  = tms_q;
        tdi_d  = tdi_q;
        if (fall_stb && !end_fall) begin
            tdi_d = 1'b0;
            case (state_q)
                RESET_SEQ: tms_d = (bit_q < RESET_TCK - 7'd1);
                IR_HDR:    tms_d = IR_HDR_TMS[bit_q[1:0]];
                IR_SHIFT:  begin tms_d = (bit_q == seg_len - 7'd1); tdi_d = ir_sh_q[0]; end
                IR_TAIL:   tms_d = IR_TAIL_TMS[bit_q[0]];
                DR_HDR:    tms_d = DR_HDR_TMS[bit_q[0]];
                DR_SHIFT:  begin tms_d = (bit_q == seg_len - 7'd1); tdi_d = dr_sh_q[0]; end
                DR_TAIL:   tms_d = DR_TAIL_TMS[bit_q[0]];
                default:   ;
            endcase
        end
    end

    // The shift registers double as transmit source and capture buffer:
    // bit 0 goes out on TDI, TDO enters at the top of the active length.
    assign dr_top = DRW'(len_q - 7'd1);

    always_comb begin
        ir_ins = ir_sh_q >> 1;
        ir_ins[IR_WIDTH-1] = jtag_tdo_i;
        dr_ins = dr_sh_q >> 1;
        dr_ins[dr_top] = jtag_tdo_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q   <= '0;
            len_q   <= '0;
            ir_sh_q <= '0;
            dr_sh_q <= '0;
            err_q   <= 1'b0;
            ir_o_q  <= '0;
            dr_o_q  <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else begin
            tms_q <= tms_d;
            tdi_q <= tdi_d;
            if (state_q != state_d) bit_q <= '0;
            else if (rise_stb)      bit_q <= bit_q + 7'd1;
            if (accept) begin
                err_q <= !len_ok;
                if (len_ok) begin
                    len_q   <= dr_len_i;
                    ir_sh_q <= ir_i;
                    // Bits above the scan length must start at 0 so they read 0.
                    dr_sh_q <= dr_i & len_mask(dr_len_i);
                end
            end
            if (rise_stb && state_q == IR_SHIFT) ir_sh_q <= ir_ins;
            if (rise_stb && state_q == DR_SHIFT) dr_sh_q <= dr_ins;
            if (state_q == DR_TAIL && state_d == DONE) begin
                ir_o_q <= ir_sh_q;
                dr_o_q <= dr_sh_q;
            end
        end
    end

    assign ir_o       = ir_o_q;
    assign dr_o       = dr_o_q;
    assign jtag_tms_o = tms_q;
    assign jtag_tdi_o = tdi_q;

endmodule

// File: tb/tb_jtag_host_driver.sv
module tb_jtag_host_driver;

    localparam int CD  = 2;
    localparam int IRW = 5;
    localparam int DRM = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_i = 1'b0, tap_reset_i = 1'b0;
    logic [IRW-1:0] ir_i = '0;
    logic [6:0]     dr_len_i = '0;
    logic [DRM-1:0] dr_i = '0;
    logic           busy_o, done_o, err_o;
    logic [IRW-1:0] ir_o;
    logic [DRM-1:0] dr_o;
    logic           jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_tdo_i;
    logic           tdo_inv = 1'b0;

    assign jtag_tdo_i = jtag_tdi_o ^ tdo_inv;

    jtag_host_driver #(.CLK_DIV(CD), .IR_WIDTH(IRW), .DR_MAX(DRM)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .tap_reset_i(tap_reset_i),
        .ir_i(ir_i), .dr_len_i(dr_len_i), .dr_i(dr_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .ir_o(ir_o), .dr_o(dr_o),
        .jtag_tck_o(jtag_tck_o), .jtag_tms_o(jtag_tms_o), .jtag_tdi_o(jtag_tdi_o),
        .jtag_tdo_i(jtag_tdo_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IRW-1:0] ir;
        logic [6:0]     len;
        logic [DRM-1:0] dr;
        bit             inv;
        bit             poke;
    } vec_t;

    typedef struct {
        logic [IRW-1:0] ir;
        logic [DRM-1:0] dr;
        logic           err;
        int             ntck;
        int             lat;
        logic [127:0]   trace;
    } exp_t;

    int           checks = 0, errors = 0;
    int           tck_cnt = 0, done_cnt = 0;
    logic [127:0] tms_log = '0;
    bit           tdi_hi = 1'b0;
    logic [IRW-1:0] hold_ir = '0;
    logic [DRM-1:0] hold_dr = '0;
    exp_t         exp_q[$];
    vec_t         vecs[7];

    // TAP-side view: TMS/TDI as sampled on each TCK rise.
    always @(posedge jtag_tck_o) begin
        if (tck_cnt < 128) tms_log[tck_cnt] = jtag_tms_o;
        if (jtag_tdi_o) tdi_hi = 1'b1;
        tck_cnt++;
    end

    always @(negedge clk) if (done_o) done_cnt++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DRM-1:0] mask_of(input int n);
        logic [DRM-1:0] m;
        for (int i = 0; i < DRM; i++) m[i] = (i < n);
        return m;
    endfunction

    // TMS per TCK for a full scan: hdr 1100, IR shift (last=1), tail 11,
    // hdr 00, DR shift (last=1), tail 10.
    function automatic logic [127:0] scan_trace(input int len);
        logic [127:0] t;
        int k;
        t = '0;
        t[0] = 1'b1; t[1] = 1'b1;
        k = 4 + IRW - 1;
        t[k] = 1'b1; k++;
        t[k] = 1'b1; t[k+1] = 1'b1; k += 4;
        k += len - 1;
        t[k] = 1'b1; k++;
        t[k] = 1'b1;
        return t;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 128'(busy_o), 128'(1));
        chk({tag, "_done"}, 128'(done_o), 128'(0));
        chk({tag, "_err"},  128'(err_o),  128'(0));
        chk({tag, "_ir"},   128'(ir_o),   128'(0));
        chk({tag, "_dr"},   128'(dr_o),   128'(0));
        chk({tag, "_tck"},  128'(jtag_tck_o), 128'(0));
        chk({tag, "_tms"},  128'(jtag_tms_o), 128'(1));
        chk({tag, "_tdi"},  128'(jtag_tdi_o), 128'(0));
    endtask

    task automatic wait_reset_seq(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 1000) begin @(negedge clk); n++; end
        chk({tag, "_busy_fall"}, 128'(busy_o), 128'(0));
        chk({tag, "_ntck"},  128'(tck_cnt), 128'(6));
        chk({tag, "_trace"}, tms_log, 128'h1F);
        chk({tag, "_tdi"},   128'(tdi_hi), 128'(0));
    endtask

    task automatic run_cmd(input string tag, input vec_t v);
        exp_t e;
        exp_t g;
        int lat;
        bit ok;
        ok = (v.len >= 1) && (v.len <= DRM);
        e.err = !ok;
        if (ok) begin
            e.ir = v.inv ? ~v.ir : v.ir;
            e.dr = (v.inv ? ~v.dr : v.dr) & mask_of(int'(v.len));
            hold_ir = e.ir;
            hold_dr = e.dr;
            e.ntck = int'(v.len) + IRW + 10;
            e.lat = 2 + 2 * CD * e.ntck;
            e.trace = scan_trace(int'(v.len));
        end else begin
            e.ir = hold_ir; e.dr = hold_dr;
            e.ntck = 0; e.lat = 1; e.trace = '0;
        end
        exp_q.push_back(e);
        @(negedge clk);
        tdo_inv = v.inv; ir_i = v.ir; dr_len_i = v.len; dr_i = v.dr;
        start_i = 1'b1; tck_cnt = 0; tms_log = '0;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
            if (lat == 1) begin
                // Operands change right after acceptance; must have no effect.
                start_i = 1'b0;
                ir_i = IRW'($urandom);
                dr_len_i = 7'($urandom);
                dr_i = {$urandom(), $urandom()};
            end
            if (v.poke && lat == 40) begin start_i = 1'b1; tap_reset_i = 1'b1; end
            if (v.poke && lat == 41) begin start_i = 1'b0; tap_reset_i = 1'b0; end
        end while (!done_o && lat < 2000);
        g = exp_q.pop_front();
        chk({tag, "_done"}, 128'(done_o), 128'(1));
        chk({tag, "_lat"},  128'(lat), 128'(g.lat));
        chk({tag, "_err"},  128'(err_o), 128'(g.err));
        chk({tag, "_ir"},   128'(ir_o), 128'(g.ir));
        chk({tag, "_dr"},   128'(dr_o), 128'(g.dr));
        chk({tag, "_ntck"}, 128'(tck_cnt), 128'(g.ntck));
        chk({tag, "_trace"}, tms_log, g.trace);
        repeat (12) @(negedge clk);
        chk({tag, "_idle"},   128'(busy_o), 128'(0));
        chk({tag, "_notck"},  128'(tck_cnt), 128'(g.ntck));
    endtask

    initial begin
        vecs[0] = '{ir: 5'h11, len: 7'd41, dr: 64'h0000_0012_3456_789A, inv: 1'b0, poke: 1'b0};
        vecs[1] = '{ir: 5'h0A, len: 7'd1,  dr: 64'h1,                   inv: 1'b1, poke: 1'b0};
        vecs[2] = '{ir: 5'h1F, len: 7'd64, dr: 64'hDEAD_BEEF_CAFE_F00D, inv: 1'b0, poke: 1'b0};
        vecs[3] = '{ir: 5'h03, len: 7'd0,  dr: '1,                      inv: 1'b0, poke: 1'b0};
        vecs[4] = '{ir: 5'h07, len: 7'd65, dr: 64'h55,                  inv: 1'b0, poke: 1'b0};
        vecs[5] = '{ir: 5'h1E, len: 7'd7,  dr: '1,                      inv: 1'b0, poke: 1'b0};
        vecs[6] = '{ir: 5'h15, len: 7'd33, dr: 64'h0123_4567_89AB_CDEF, inv: 1'b1, poke: 1'b1};

        // Reset values, then the automatic reset sequence.
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1; tck_cnt = 0; tms_log = '0; tdi_hi = 1'b0;
        wait_reset_seq("rstseq");

        foreach (vecs[i]) run_cmd($sformatf("vec%0d", i), vecs[i]);

        // start_i and tap_reset_i together: only the reset sequence runs.
        begin
            int d0;
            @(negedge clk);
            d0 = done_cnt;
            ir_i = 5'h09; dr_len_i = 7'd8; dr_i = 64'hFF;
            start_i = 1'b1; tap_reset_i = 1'b1;
            tck_cnt = 0; tms_log = '0; tdi_hi = 1'b0;
            @(posedge clk); #1;
            start_i = 1'b0; tap_reset_i = 1'b0;
            wait_reset_seq("both");
            chk("both_nodone", 128'(done_cnt), 128'(d0));
            chk("both_dr",     128'(dr_o), 128'(hold_dr));
        end

        // Async reset in the middle of a scan.
        begin
            int n;
            @(negedge clk);
            tdo_inv = 1'b0; ir_i = 5'h11; dr_len_i = 7'd20; dr_i = 64'hABCDE;
            start_i = 1'b1; tck_cnt = 0;
            @(negedge clk);
            start_i = 1'b0;
            n = 0;
            while (tck_cnt < 20 && n < 2000) begin @(negedge clk); n++; end
            chk("mid_reach20", 128'(tck_cnt), 128'(20));
            #3 rst_n = 1'b0;
            #1 check_reset_vals("mid");
            hold_ir = '0; hold_dr = '0;
            @(negedge clk);
            rst_n = 1'b1; tck_cnt = 0; tms_log = '0; tdi_hi = 1'b0;
            wait_reset_seq("midseq");
            run_cmd("after", '{ir: 5'h01, len: 7'd32, dr: 64'hA5A5_5A5A, inv: 1'b0, poke: 1'b0});
            run_cmd("after_err", '{ir: 5'h02, len: 7'd0, dr: 64'h0, inv: 1'b0, poke: 1'b0});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
